// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if : instruction-memory request/grant + response bus.
// The master (fetch unit) issues one word request at a time and receives the
// response on the rvalid/rdata pair; the slave is the instruction memory.
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit : fetch stage holding the architectural PC.
// Fetches one instruction at a time over the imem request/grant + response
// bus, buffers it and hands it to decode with a valid/ready handshake.
// A flush redirects the PC; a response still in flight at that moment is
// drained and thrown away so only one request is ever outstanding.
// Optional build macro FETCH_ALIGN_CHK_EN: a misaligned PC is never sent to
// memory; instead a zero instruction is presented with fetch_fault set.
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         npc_in,
    output logic [31:0]         pc_out,
    input  logic                flush,
    input  logic [31:0]         flush_pc,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr_out,
    output logic                instr_valid,
    input  logic                id_ready
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic                fetch_fault
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        gnt_acc_s;
    logic        misalign_s;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fault_q, fault_d;
`endif

    // Alignment test on the held PC; a constant 0 when checking is compiled out.
    always_comb begin
`ifdef FETCH_ALIGN_CHK_EN
        misalign_s = (pc_q[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
    end

    // Request is a pure decode of the state so it is held steadily until granted.
    always_comb begin
        imem.imem_req  = (state_q == S_REQ) && !rst && !misalign_s;
        imem.imem_addr = {pc_q[31:2], 2'b00};
        gnt_acc_s      = imem.imem_req && imem.imem_gnt;
    end

    // Next-state and datapath update; flush overrides acceptance and responses.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
        fault_d = fault_q;
`endif
        if (flush) begin
            pc_d    = flush_pc;
            valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            fault_d = 1'b0;
`endif
            case (state_q)
                // A grant in the flush cycle leaves a response in flight.
                S_REQ:   state_d = gnt_acc_s ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
                S_HOLD:  state_d = S_REQ;
                S_DRAIN: state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (misalign_s) begin
                        instr_d = 32'h0000_0000;
                        valid_d = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
                        fault_d = 1'b1;
`endif
                        state_d = S_HOLD;
                    end else if (gnt_acc_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        instr_d = imem.imem_rdata;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                        fault_d = 1'b0;
`endif
                        pc_d    = npc_in;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                // Orphaned response after a flush: swallow it, never present it.
                S_DRAIN: begin
                    if (imem.imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        pc_out      = pc_q;
        instr_out   = instr_q;
        instr_valid = valid_q;
`ifdef FETCH_ALIGN_CHK_EN
        fetch_fault = fault_q;
`endif
    end

endmodule
